// File: rtl/des_sbox_engine.sv
// des_sbox_engine: applies the eight DES S-boxes (S1..S8) to a 48-bit
// expanded, key-mixed half-block and returns the 32-bit substituted word.
// The eight box lookups are time-multiplexed over LANES lookup units, so one
// word takes BEATS = 8/LANES cycles of substitution. Both the input and the
// output side use valid/ready handshakes.
module des_sbox_engine #(
    parameter int LANES = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    // Only lane counts that divide the eight boxes evenly are supported.
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : gBadLanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    if (CNT_W < 1) begin : gBadCntW
        $error("des_sbox_engine: CNT_W must be at least 1");
    end

    localparam int BEATS = 8 / LANES;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    // One 256-bit constant per box: four rows of sixteen nibbles, row 0 in
    // the top 64 bits and column 0 in the top nibble of each row, so entry
    // (row, col) is nibble number row*16+col counted from the MSB end.
    localparam logic [255:0] SBOX_ROM [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Row is formed from the outer bits {b5,b0}, column from the inner b[4:1];
    // concatenating them gives the linear entry index directly.
    function automatic logic [3:0] sboxLookup(input logic [2:0] box, input logic [5:0] field);
        logic [5:0] entry;
        entry = {field[5], field[0], field[4:1]};
        return SBOX_ROM[box][255 - 4 * int'(entry) -: 4];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               w_accept;
    logic [2:0]         r_beat;
    logic [47:0]        r_work;
    logic [31:0]        r_result;
    logic [CNT_W-1:0]   r_wordsDone;
    logic [2:0]         w_box [LANES];
    logic [3:0]         w_nib [LANES];

    // State register; reset drops any word in flight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and input handshake. HOLD can hand off straight into SUB
    // when the consumer takes the result in the same cycle a new word arrives.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = S_SUB;
                end
            end
            S_SUB: begin
                if (r_beat == LAST_BEAT) begin
                    w_nextState = S_HOLD;
                end
            end
            S_HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_accept    = 1'b1;
                        w_nextState = S_SUB;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Lane lookups: on beat n, lane l serves box n*LANES+l, so the
    // lowest-numbered remaining boxes are always processed first.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_box[l] = 3'(int'(r_beat) * LANES + l);
            w_nib[l] = sboxLookup(w_box[l], r_work[6 * (7 - int'(w_box[l])) +: 6]);
        end
    end

    // Datapath: capture the word on accept, then drop each lane's nibble into
    // its box's fixed slot of the result word as the beats advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work   <= '0;
            r_beat   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_work <= in_data;
            r_beat <= '0;
        end else if (r_state == S_SUB) begin
            r_beat <= r_beat + 3'd1;
            for (int l = 0; l < LANES; l++) begin
                r_result[4 * (7 - int'(w_box[l])) +: 4] <= w_nib[l];
            end
        end
    end

    // Completed-word counter, stepped on each output handshake; wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wordsDone <= '0;
        end else if (r_state == S_HOLD && out_ready) begin
            r_wordsDone <= r_wordsDone + CNT_W'(1);
        end
    end

    assign out_valid  = (r_state == S_HOLD);
    assign busy       = (r_state == S_SUB);
    assign out_data   = r_result;
    assign words_done = r_wordsDone;

endmodule

// File: tb/tb_des_sbox_engine.sv
// tb_des_sbox_engine: drives four engines (LANES = 1, 2, 4, 8, all with a
// 4-bit word counter) and compares every output, every cycle, against a
// whole-word reference built from the FIPS 46-3 S-box tables.
module tb_des_sbox_engine;

    localparam int N = 4;

    localparam int SBOX_TAB [8][4][16] = '{
        '{ '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7},
           '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
           '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0},
           '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13} },
        '{ '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10},
           '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
           '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15},
           '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9} },
        '{ '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8},
           '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
           '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7},
           '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12} },
        '{ '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15},
           '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
           '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4},
           '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14} },
        '{ '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9},
           '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
           '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14},
           '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3} },
        '{ '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11},
           '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
           '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6},
           '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13} },
        '{ '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1},
           '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
           '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2},
           '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12} },
        '{ '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7},
           '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
           '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8},
           '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11} }
    };

    logic        clk;
    logic        rst;
    logic        inValid   [N];
    logic        inReady   [N];
    logic [47:0] inData    [N];
    logic        outValid  [N];
    logic        outReady  [N];
    logic [31:0] outData   [N];
    logic        busy      [N];
    logic [3:0]  wordsDone [N];

    int checks = 0;
    int errors = 0;
    bit checkEnable = 0;

    int          mRemaining [N];
    bit          mHolding   [N];
    logic [31:0] mResult    [N];
    logic [3:0]  mDone      [N];

    for (genvar g = 0; g < N; g++) begin : gDut
        des_sbox_engine #(.LANES(1 << g), .CNT_W(4)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (inValid[g]),
            .in_ready   (inReady[g]),
            .in_data    (inData[g]),
            .out_valid  (outValid[g]),
            .out_ready  (outReady[g]),
            .out_data   (outData[g]),
            .busy       (busy[g]),
            .words_done (wordsDone[g])
        );
    end

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a wedged run still terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Whole-word software S-box: eight independent table lookups.
    function automatic logic [31:0] desSbox(input logic [47:0] d);
        logic [31:0] res;
        logic [5:0]  six;
        int          row;
        int          col;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            six = d[47 - 6 * i -: 6];
            row = int'(six[5]) * 2 + int'(six[0]);
            col = int'(six[4:1]);
            res[31 - 4 * i -: 4] = 4'(SBOX_TAB[i][row][col]);
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input logic valid, input logic [47:0] data, input logic ready);
        inValid[k]  = valid;
        inData[k]   = data;
        outReady[k] = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid, counting cycles and how many of them showed busy.
    task automatic waitValid(input int k, input int maxCycles, output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        while (outValid[k] !== 1'b1 && lat < maxCycles) begin
            if (busy[k] === 1'b1) busyCnt++;
            tick();
            lat++;
        end
        if (outValid[k] !== 1'b1) begin
            checkOutput($sformatf("timeout waiting out_valid lane%0d", k), 64'(outValid[k]), 64'd1);
        end
    endtask

    // Reference timeline: a word accepted at an edge finishes BEATS edges
    // later, then waits in the output slot until the consumer takes it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mRemaining[k] = 0;
                mHolding[k]   = 0;
                mResult[k]    = '0;
                mDone[k]      = '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (mHolding[k]) begin
                    if (outReady[k]) begin
                        mDone[k]    = mDone[k] + 4'd1;
                        mHolding[k] = 0;
                        if (inValid[k]) begin
                            mResult[k]    = desSbox(inData[k]);
                            mRemaining[k] = 8 >> k;
                        end
                    end
                end else if (mRemaining[k] > 0) begin
                    mRemaining[k]--;
                    if (mRemaining[k] == 0) mHolding[k] = 1;
                end else if (inValid[k]) begin
                    mResult[k]    = desSbox(inData[k]);
                    mRemaining[k] = 8 >> k;
                end
            end
        end
    end

    // Per-cycle comparison of every engine against the reference.
    always @(negedge clk) begin
        if (checkEnable) begin
            for (int k = 0; k < N; k++) begin
                checkOutput($sformatf("in_ready lane%0d", k), 64'(inReady[k]),
                            64'((!mHolding[k] && mRemaining[k] == 0) || (mHolding[k] && outReady[k])));
                checkOutput($sformatf("out_valid lane%0d", k), 64'(outValid[k]), 64'(mHolding[k]));
                checkOutput($sformatf("busy lane%0d", k), 64'(busy[k]), 64'(mRemaining[k] > 0));
                checkOutput($sformatf("words_done lane%0d", k), 64'(wordsDone[k]), 64'(mDone[k]));
                if (mHolding[k]) begin
                    checkOutput($sformatf("out_data lane%0d", k), 64'(outData[k]), 64'(mResult[k]));
                end
            end
        end
    end

    // Directed scenarios, then randomized traffic on all engines at once.
    initial begin
        int lat;
        int busyCnt;
        logic [47:0] wordA;
        logic [47:0] wordB;

        rst = 1'b1;
        for (int k = 0; k < N; k++) applyStimulus(k, 1'b0, 48'd0, 1'b0);

        checkOutput("model all-zero", 64'(desSbox(48'h000000000000)), 64'hEFA72C4D);
        checkOutput("model all-ones", 64'(desSbox(48'hFFFFFFFFFFFF)), 64'hD9CE3DCB);
        checkOutput("model S5 row2", 64'(desSbox(48'h000000C00000)), 64'hEFA7FC4D);

        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("reset out_valid lane%0d", k), 64'(outValid[k]), 64'd0);
            checkOutput($sformatf("reset out_data lane%0d", k), 64'(outData[k]), 64'd0);
            checkOutput($sformatf("reset busy lane%0d", k), 64'(busy[k]), 64'd0);
            checkOutput($sformatf("reset words_done lane%0d", k), 64'(wordsDone[k]), 64'd0);
            checkOutput($sformatf("reset in_ready lane%0d", k), 64'(inReady[k]), 64'd1);
        end
        checkEnable = 1;

        $display("[TB] LANES=8 all-zero word");
        applyStimulus(3, 1'b1, 48'h000000000000, 1'b0);
        tick();
        applyStimulus(3, 1'b0, 48'hFFFF00000000, 1'b0);
        waitValid(3, 20, lat, busyCnt);
        checkOutput("L8 latency", 64'(lat), 64'd1);
        checkOutput("L8 zero word", 64'(outData[3]), 64'hEFA72C4D);
        applyStimulus(3, 1'b0, 48'd0, 1'b1);
        tick();
        checkOutput("L8 words_done", 64'(wordsDone[3]), 64'd1);
        applyStimulus(3, 1'b0, 48'd0, 1'b0);

        $display("[TB] LANES=1 all-ones word");
        applyStimulus(0, 1'b1, 48'hFFFFFFFFFFFF, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 48'h0, 1'b0);
        waitValid(0, 20, lat, busyCnt);
        checkOutput("L1 latency", 64'(lat), 64'd8);
        checkOutput("L1 busy cycles", 64'(busyCnt), 64'd8);
        checkOutput("L1 ones word", 64'(outData[0]), 64'hD9CE3DCB);
        applyStimulus(0, 1'b0, 48'd0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 48'd0, 1'b0);

        $display("[TB] LANES=2 S5 row-2 word");
        applyStimulus(1, 1'b1, 48'h000000C00000, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 48'h0, 1'b0);
        waitValid(1, 20, lat, busyCnt);
        checkOutput("L2 latency", 64'(lat), 64'd4);
        checkOutput("L2 S5 word", 64'(outData[1]), 64'hEFA7FC4D);
        applyStimulus(1, 1'b0, 48'd0, 1'b1);
        tick();
        applyStimulus(1, 1'b0, 48'd0, 1'b0);

        $display("[TB] LANES=4 backpressure");
        wordA = {$urandom, $urandom};
        wordB = {$urandom, $urandom};
        applyStimulus(2, 1'b1, wordA, 1'b0);
        tick();
        applyStimulus(2, 1'b1, wordB, 1'b0);
        waitValid(2, 20, lat, busyCnt);
        checkOutput("L4 latency", 64'(lat), 64'd2);
        for (int c = 0; c < 10; c++) begin
            checkOutput("L4 stall in_ready", 64'(inReady[2]), 64'd0);
            checkOutput("L4 stall out_data", 64'(outData[2]), 64'(desSbox(wordA)));
            tick();
        end
        applyStimulus(2, 1'b1, wordB, 1'b1);
        #1;
        checkOutput("L4 release in_ready", 64'(inReady[2]), 64'd1);
        tick();
        applyStimulus(2, 1'b0, 48'd0, 1'b0);
        checkOutput("L4 after handoff out_valid", 64'(outValid[2]), 64'd0);
        checkOutput("L4 after handoff words_done", 64'(wordsDone[2]), 64'd1);
        waitValid(2, 20, lat, busyCnt);
        checkOutput("L4 second latency", 64'(lat), 64'd2);
        checkOutput("L4 second word", 64'(outData[2]), 64'(desSbox(wordB)));
        applyStimulus(2, 1'b0, 48'd0, 1'b1);
        tick();
        applyStimulus(2, 1'b0, 48'd0, 1'b0);

        $display("[TB] LANES=1 reset mid-substitution");
        applyStimulus(0, 1'b1, {$urandom, $urandom}, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 48'd0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("mid-reset out_valid", 64'(outValid[0]), 64'd0);
        checkOutput("mid-reset busy", 64'(busy[0]), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", 64'(inReady[0]), 64'd1);
        checkOutput("post-reset words_done", 64'(wordsDone[0]), 64'd0);
        applyStimulus(0, 1'b1, 48'h000000000000, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 48'h123456789ABC, 1'b0);
        waitValid(0, 20, lat, busyCnt);
        checkOutput("post-reset latency", 64'(lat), 64'd8);
        checkOutput("post-reset zero word", 64'(outData[0]), 64'hEFA72C4D);
        applyStimulus(0, 1'b0, 48'd0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 48'd0, 1'b0);

        $display("[TB] LANES=8 counter wrap over 17 words");
        for (int c = 0; c < 33; c++) begin
            applyStimulus(3, 1'b1, {$urandom, $urandom}, 1'b1);
            tick();
        end
        applyStimulus(3, 1'b0, 48'd0, 1'b1);
        tick();
        tick();
        checkOutput("wrap words_done", 64'(wordsDone[3]), 64'd1);
        applyStimulus(3, 1'b0, 48'd0, 1'b0);

        $display("[TB] randomized traffic on all engines");
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                applyStimulus(k, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                              1'($urandom_range(0, 3) != 0));
            end
            tick();
        end
        for (int k = 0; k < N; k++) applyStimulus(k, 1'b0, 48'd0, 1'b1);
        for (int c = 0; c < 12; c++) tick();
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("drained out_valid lane%0d", k), 64'(outValid[k]), 64'd0);
        end

        checkEnable = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_sbox_engine.md
# des_sbox_engine

Parametrised DES S-box substitution engine. It applies all eight DES S-boxes (S1–S8) to a 48-bit expanded, key-mixed half-block and returns the 32-bit substituted word. The datapath can be time-multiplexed over 1, 2, 4 or 8 lanes, and both sides use valid/ready handshakes. It sits between the E-expansion/key-XOR stage and the P-permutation in each round of the DES datapath, and replaces the per-box combinational lookups.

## Interface
- LANES, 8, S-boxes evaluated per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error
- CNT_W, 16, width of the completed-word counter
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  engine accepts in_data this cycle
- in_data  input  48  S1 field in [47:42], down to S8 field in [5:0]
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  32  S1 result in [31:28], down to S8 result in [3:0]
- busy  output  1  a word is being substituted (state SUB)
- words_done  output  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W

## Operation
- Per 6-bit field b[5:0]: row = {b5,b0}, column = b[4:1]. The output nibble is the standard FIPS 46-3 table entry for that box. All eight tables are held as constant ROMs.
- BEATS = 8/LANES.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into the working register, clear the beat counter, go to SUB.
- State SUB:
  - Each cycle, substitute the LANES lowest-numbered remaining boxes (S1 first) and write their nibbles into the result register at fixed positions.
  - Increment the beat counter.
  - After beat BEATS-1 completes, go to HOLD.
- State HOLD:
  - out_valid = 1; out_data = result register.
  - On out_ready: increment words_done.
  - If in_valid is also high in the same cycle, accept the new word and go directly to SUB. Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is combinational from out_ready; there is no path from in_valid.
- out_data and out_valid stay stable while out_valid & !out_ready.
- in_data is sampled only on the accepting edge. Later changes to in_data have no effect on the word in progress.

## Timing
- Reset values (asynchronous, immediate on rst):
  - state = IDLE, so in_ready reads 1 once rst deasserts.
  - out_valid = 0, out_data = 0, busy = 0, words_done = 0.
  - Beat counter and working register = 0.
- Latency: accept at edge T; out_valid rises after edge T+BEATS.
  - LANES=8: 1 cycle.
  - LANES=1: 8 cycles.
- Sustained throughput with out_ready tied high is 1 word per BEATS+1 cycles, because the HOLD cycle overlaps the next accept.
- busy is high for exactly BEATS cycles per word.
- Reset mid-SUB or mid-HOLD: the partial or undelivered word is discarded, with no output handshake and no words_done increment.
- words_done at all ones plus one completion wraps to 0.
- out_ready held low in HOLD: the engine holds indefinitely, in_ready = 0, and no input is lost.

## Test plan
- LANES=8, in_data=0x000000000000 → out_data=0xEFA72C4D; out_valid 1 cycle after accept; words_done=1.
- LANES=1, in_data=0xFFFFFFFFFFFF → out_data=0xD9CE3DCB; out_valid 8 cycles after accept; busy high for exactly 8 cycles.
- LANES=2, in_data=0x000000C00000 (S5 field 6'b110000) → out_data=0xEFA7FC4D.
- Backpressure, LANES=4:
  - Stimulus: out_ready low for 10 cycles with in_valid held high.
  - Required response: out_data stable, in_ready=0. When out_ready rises, the next word is accepted in that same cycle, and its result appears 2 cycles later.
- Reset during SUB (LANES=1, beat 3): asserting rst → out_valid=0, busy=0 and in_ready=1 immediately after release. A following all-zero word still gives 0xEFA72C4D.
- CNT_W=4: 17 back-to-back words → words_done = 1 after wrap. Random 48-bit inputs across all four LANES values match the software DES S-box model.
